// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multi-register opcode patterns, sequencer states and
// architectural register indices used by the LDM/STM sequencer and data_mem.
package cpu_pkg;

    localparam logic [4:0] OP_STM  = 5'b11000;   // instr[15:11]
    localparam logic [4:0] OP_LDM  = 5'b11001;   // instr[15:11]
    localparam logic [6:0] OP_PUSH = 7'b1011010;
    localparam logic [6:0] OP_POP  = 7'b1011110;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        K_NONE,
        K_STM,
        K_LDM,
        K_PUSH,
        K_POP
    } xfer_kind_t;

    function automatic xfer_kind_t decode_kind(input logic [6:0] op);
        if (op[6:2] == OP_STM)  return K_STM;
        if (op[6:2] == OP_LDM)  return K_LDM;
        if (op == OP_PUSH)      return K_PUSH;
        if (op == OP_POP)       return K_POP;
        return K_NONE;
    endfunction

endpackage

// File: rtl/reg_list_pri_enc.sv
// Lowest-set-bit encoder over a 16-entry register list.
module reg_list_pri_enc (
    input  logic [15:0] list_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (list_i[i] && !valid_o) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle PUSH/POP/STMIA/LDMIA sequencer: one memory word per cycle,
// load writeback one cycle after issue, single base writeback on completion.
module ldm_stm_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       instr,
    input  logic [ADDR_W-1:0] base_val,
    output logic [3:0]        reg_rd_addr,
    input  logic [31:0]       reg_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [6:0]        mem_op,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              base_wb_en,
    output logic [3:0]        base_wb_addr,
    output logic [ADDR_W-1:0] base_wb_data,
    output logic              stall,
    output logic              done
);

    seq_state_t        state_q;
    logic [15:0]       list_q;
    logic              is_load_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [6:0]        mem_op_q;
    logic              mem_we_q;
    logic              wb_en_q;
    logic [3:0]        wb_addr_q;
    logic [ADDR_W-1:0] base_new_q;
    logic [3:0]        base_reg_q;
    logic              base_ok_q;
    logic              done_q;
    logic              base_wb_en_q;
    logic [3:0]        base_wb_addr_q;
    logic [ADDR_W-1:0] base_wb_data_q;

    xfer_kind_t        kind;
    logic [15:0]       list_dec;
    logic [3:0]        rn_dec;
    logic [4:0]        cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] base_new;
    logic [3:0]        base_reg;
    logic              base_ok;
    logic              is_load_dec;
    logic              accept;

    logic [3:0]        cur_idx;
    logic              cur_valid;
    logic [15:0]       list_rest;

    always_comb begin
        kind     = decode_kind(instr[15:9]);
        rn_dec   = {1'b0, instr[10:8]};
        list_dec = '0;
        unique case (kind)
            K_STM, K_LDM: list_dec = {8'h00, instr[7:0]};
            K_PUSH:       list_dec = {1'b0, instr[8], 6'b0, instr[7:0]};
            K_POP:        list_dec = {instr[8], 7'b0, instr[7:0]};
            default:      list_dec = '0;
        endcase

        cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            cnt = cnt + 5'(list_dec[i]);
        end

        span        = ADDR_W'({cnt, 2'b00});
        start_addr  = (kind == K_PUSH) ? base_val - span : base_val;
        base_new    = (kind == K_PUSH) ? base_val - span : base_val + span;
        base_reg    = (kind == K_PUSH || kind == K_POP) ? REG_SP : rn_dec;
        // LDM that reloads its own base keeps the loaded value, not base+4N
        base_ok     = !(kind == K_LDM && list_dec[rn_dec]);
        is_load_dec = (kind == K_LDM || kind == K_POP);
        accept      = (state_q == S_IDLE) && start && (kind != K_NONE);
    end

    reg_list_pri_enc u_pri_enc (
        .list_i  (list_q),
        .idx_o   (cur_idx),
        .valid_o (cur_valid)
    );

    assign list_rest = list_q & (list_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            list_q         <= '0;
            is_load_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_op_q       <= '0;
            mem_we_q       <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            base_new_q     <= '0;
            base_reg_q     <= '0;
            base_ok_q      <= 1'b0;
            done_q         <= 1'b0;
            base_wb_en_q   <= 1'b0;
            base_wb_addr_q <= '0;
            base_wb_data_q <= '0;
        end else begin
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            done_q         <= 1'b0;
            base_wb_en_q   <= 1'b0;
            base_wb_addr_q <= '0;
            base_wb_data_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        list_q     <= list_dec;
                        is_load_q  <= is_load_dec;
                        mem_op_q   <= instr[15:9];
                        base_new_q <= base_new;
                        base_reg_q <= base_reg;
                        base_ok_q  <= base_ok;
                        if (cnt == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_XFER;
                            mem_addr_q <= start_addr;
                            mem_we_q   <= !is_load_dec;
                        end
                    end
                end
                S_XFER: begin
                    list_q    <= list_rest;
                    wb_en_q   <= is_load_q;
                    wb_addr_q <= is_load_q ? cur_idx : '0;
                    if (list_rest == '0) begin
                        mem_we_q <= 1'b0;
                        if (is_load_q) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q        <= S_DONE;
                            done_q         <= 1'b1;
                            base_wb_en_q   <= base_ok_q;
                            base_wb_addr_q <= base_reg_q;
                            base_wb_data_q <= base_new_q;
                        end
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_W'(4);
                    end
                end
                S_DRAIN: begin
                    state_q        <= S_DONE;
                    done_q         <= 1'b1;
                    base_wb_en_q   <= base_ok_q;
                    base_wb_addr_q <= base_reg_q;
                    base_wb_data_q <= base_new_q;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_rd_addr  = (state_q == S_XFER && !is_load_q && cur_valid) ? cur_idx : '0;
    assign mem_addr     = mem_addr_q;
    assign mem_write_en = mem_we_q;
    assign mem_op       = mem_op_q;
    assign mem_wdata    = mem_we_q ? reg_rd_data : '0;
    assign wb_en        = wb_en_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_en_q ? mem_rdata : '0;
    assign base_wb_en   = base_wb_en_q;
    assign base_wb_addr = base_wb_addr_q;
    assign base_wb_data = base_wb_data_q;
    assign stall        = accept || (state_q == S_XFER) || (state_q == S_DRAIN);
    assign done         = done_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Cycle-level scoreboard bench for ldm_stm_sequencer: each launched instruction
// queues its expected per-cycle outputs, popped and compared every cycle.
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic [31:0] base_val;
    logic [3:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [6:0]  mem_op;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        base_wb_en;
    logic [3:0]  base_wb_addr;
    logic [31:0] base_wb_data;
    logic        stall;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        we;
        logic        chk_addr;
        logic [31:0] addr;
        logic [6:0]  op;
        logic [31:0] wdata;
        logic        wb;
        logic [3:0]  wba;
        logic [31:0] wbd;
        logic        bwb;
        logic [3:0]  bwa;
        logic [31:0] bwd;
        logic        done;
    } exp_t;

    exp_t exp_q[$];

    ldm_stm_sequencer #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .instr        (instr),
        .base_val     (base_val),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_data  (reg_rd_data),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_op       (mem_op),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .base_wb_en   (base_wb_en),
        .base_wb_addr (base_wb_addr),
        .base_wb_data (base_wb_data),
        .stall        (stall),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input int r);
        return 32'hC0DE_0000 + 32'(r) * 32'h0000_0101;
    endfunction

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A00_00C3;
    endfunction

    assign reg_rd_data = reg_val(int'(reg_rd_addr));

    // data_mem stand-in: registered read, valid the cycle after the address
    always @(posedge clk) mem_rdata <= mem_f(mem_addr);

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = idle_exp();
        check_eq("stall", 32'(stall), 32'(e.stall));
        check_eq("mem_write_en", 32'(mem_write_en), 32'(e.we));
        check_eq("wb_en", 32'(wb_en), 32'(e.wb));
        check_eq("base_wb_en", 32'(base_wb_en), 32'(e.bwb));
        check_eq("done", 32'(done), 32'(e.done));
        if (e.chk_addr) begin
            check_eq("mem_addr", mem_addr, e.addr);
            check_eq("mem_op", 32'(mem_op), 32'(e.op));
        end
        if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
        if (e.wb) begin
            check_eq("wb_addr", 32'(wb_addr), 32'(e.wba));
            check_eq("wb_data", wb_data, e.wbd);
        end
        if (e.bwb) begin
            check_eq("base_wb_addr", 32'(base_wb_addr), 32'(e.bwa));
            check_eq("base_wb_data", base_wb_data, e.bwd);
        end
        @(posedge clk);
        #1;
    endtask

    // Expected trace for one instruction accepted from IDLE in the current cycle
    task automatic gen(input logic [15:0] ins, input logic [31:0] base);
        logic [6:0]  op;
        logic [2:0]  rn;
        int          kind;
        logic [15:0] lst;
        int          regs[$];
        int          n;
        logic [31:0] sa;
        logic [31:0] bwd;
        logic [3:0]  bwa;
        logic        ben;
        logic        ld;
        exp_t        e;
        op = ins[15:9];
        rn = ins[10:8];
        if (op[6:2] == 5'b11000)      kind = 1;
        else if (op[6:2] == 5'b11001) kind = 2;
        else if (op == 7'b1011010)    kind = 3;
        else if (op == 7'b1011110)    kind = 4;
        else                          kind = 0;
        if (kind == 0) begin
            exp_q.push_back(idle_exp());
            return;
        end
        lst = {8'h00, ins[7:0]};
        if (kind == 3) lst[14] = ins[8];
        if (kind == 4) lst[15] = ins[8];
        for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
        n   = regs.size();
        sa  = (kind == 3) ? base - 32'(4 * n) : base;
        bwd = (kind == 3) ? base - 32'(4 * n) : base + 32'(4 * n);
        bwa = (kind >= 3) ? 4'd13 : {1'b0, rn};
        ben = !(kind == 2 && lst[rn]);
        ld  = (kind == 2 || kind == 4);

        e = idle_exp();
        e.stall = 1'b1;
        exp_q.push_back(e);
        if (n == 0) begin
            e = idle_exp();
            e.done = 1'b1;
            exp_q.push_back(e);
            return;
        end
        for (int k = 0; k < n; k++) begin
            e = idle_exp();
            e.stall    = 1'b1;
            e.chk_addr = 1'b1;
            e.addr     = sa + 32'(4 * k);
            e.op       = op;
            e.we       = !ld;
            e.wdata    = reg_val(regs[k]);
            if (ld && k > 0) begin
                e.wb  = 1'b1;
                e.wba = 4'(regs[k-1]);
                e.wbd = mem_f(sa + 32'(4 * (k - 1)));
            end
            exp_q.push_back(e);
        end
        if (ld) begin
            e = idle_exp();
            e.stall = 1'b1;
            e.wb    = 1'b1;
            e.wba   = 4'(regs[n-1]);
            e.wbd   = mem_f(sa + 32'(4 * (n - 1)));
            exp_q.push_back(e);
        end
        e = idle_exp();
        e.done = 1'b1;
        e.bwb  = ben;
        e.bwa  = bwa;
        e.bwd  = bwd;
        exp_q.push_back(e);
    endtask

    task automatic launch(input logic [15:0] ins, input logic [31:0] base);
        start    = 1'b1;
        instr    = ins;
        base_val = base;
        gen(ins, base);
        step();
        start = 1'b0;
    endtask

    task automatic drain_q();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) step();
        check_eq("trace_drained", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    task automatic run_op(input logic [15:0] ins, input logic [31:0] base);
        launch(ins, base);
        drain_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst      = 1'b1;
        start    = 1'b0;
        instr    = '0;
        base_val = '0;
        repeat (3) @(posedge clk);
        #1;
        e = idle_exp();
        e.chk_addr = 1'b1;
        exp_q.push_back(e);
        step();
        check_eq("reset_reg_rd_addr", 32'(reg_rd_addr), 32'd0);
        rst = 1'b0;
        step();

        run_op(16'hB505, 32'h0000_0100);   // PUSH {R0,R2,LR}, SP=0x100
        run_op(16'hBD02, 32'h0000_00F8);   // POP {R1,PC}, SP=0xF8
        run_op(16'hCB18, 32'h0000_0040);   // LDMIA R3!,{R3,R4}
        run_op(16'hC320, 32'h0000_0040);   // STMIA R3!,{R5}
        run_op(16'hC000, 32'h0000_0200);   // STMIA R0!,{} empty list
        run_op(16'h0000, 32'h0000_1234);   // not a multi-register opcode
        run_op(16'hBDFF, 32'h0000_0500);   // POP {R0-R7,PC}, N=9
        run_op(16'hC8FF, 32'hFFFF_FFF0);   // LDMIA R0!,{R0-R7}, wraps past 0

        // start pulsed during XFER must not disturb the running STM
        launch(16'hC1C1, 32'h0000_1000);   // STMIA R1!,{R0,R6,R7}
        start    = 1'b1;
        instr    = 16'hB505;
        base_val = 32'h0000_0100;
        step();
        start = 1'b0;
        drain_q();

        // reset at T+2 of a 4-register POP, then PUSH with SP wrap
        launch(16'hBC0F, 32'h0000_0300);   // POP {R0-R3}
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0;
        start    = 1'b1;
        instr    = 16'hB406;               // PUSH {R1,R2}, SP=0x4
        base_val = 32'h0000_0004;
        gen(instr, base_val);
        e = exp_q.pop_front();
        e.chk_addr = 1'b1;                 // reset cleared address and opcode
        e.addr     = '0;
        e.op       = '0;
        exp_q.push_front(e);
        step();
        start = 1'b0;
        drain_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle sequencer for Thumb PUSH, POP, STMIA and LDMIA, between the execute stage and `data_mem`. It accepts one multi-register instruction and stalls the pipeline while it transfers one word per cycle. For each transfer it drives address, data, write enable and opcode into `data_mem`, and it returns load data to the register file. It finishes with one base-register writeback.

## Interface
Parameters:
- `ADDR_W`, 32, width of base value and memory address.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  execute stage presents a multi-register instruction.
- `instr`  in  16  instruction word; bits 15:9 are the opcode.
- `base_val`  in  32  value of Rn (STM/LDM) or SP (PUSH/POP), sampled on accept.
- `reg_rd_addr`  out  4  register-file read index for store data.
- `reg_rd_data`  in  32  combinational register-file read data.
- `mem_addr`  out  32  byte address to `data_mem`.
- `mem_write_en`  out  1  store strobe to `data_mem`.
- `mem_op`  out  7  opcode to `data_mem` (= latched `instr[15:9]`).
- `mem_wdata`  out  32  store data to `data_mem`.
- `mem_rdata`  in  32  `data_mem` read data, valid one cycle after issue.
- `wb_en`, `wb_addr[3:0]`, `wb_data[31:0]`  out  load writeback port.
- `base_wb_en`, `base_wb_addr[3:0]`, `base_wb_data[31:0]`  out  base writeback port.
- `stall`  out  1  holds upstream pipeline stages.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Decode on `instr[15:9]`:
  - STM `11000??`: Rn=`instr[10:8]`, list=`instr[7:0]`.
  - LDM `11001??`: same fields as STM.
  - PUSH `1011010`: list=`instr[7:0]`, `instr[8]` maps to R14.
  - POP `1011110`: list=`instr[7:0]`, `instr[8]` maps to R15.
- Any other opcode with `start` is ignored and the block stays in IDLE.
- Working list is 16 bits; count N = popcount, range 0..9.
- Start address:
  - PUSH: `base_val − 4N`.
  - POP, STM, LDM: `base_val`.
- Lowest-numbered register goes to the lowest address; address increments by 4 per transfer. Arithmetic is modulo 2^32 and wraps silently.
- Base writeback data:
  - PUSH: SP−4N.
  - POP and STM: base+4N.
  - LDM: base+4N, but only if Rn is not in the list; otherwise `base_wb_en` stays 0.
- `base_wb_addr` is 13 for PUSH/POP and Rn for STM/LDM.
- FSM states IDLE, XFER, DRAIN, DONE:
  - IDLE → XFER on an accepted `start` with N>0.
  - IDLE → DONE on an accepted `start` with N=0: no memory access, no writeback of any kind.
  - XFER: each cycle issues the lowest set bit of the list, then clears it.
  - After the last issue: loads go to DRAIN, stores go to DONE.
  - DRAIN → DONE.
  - DONE → IDLE.
- Store issue (XFER):
  - `reg_rd_addr` = current register.
  - `mem_wdata` = `reg_rd_data`, same cycle.
  - `mem_write_en` = 1.
- Load issue: `mem_write_en` = 0. One cycle later: `wb_en`=1, `wb_addr` = that register, `wb_data` = `mem_rdata`.
- `stall` = (IDLE & accepted `start`) | XFER | DRAIN. It is low in DONE.
- `done` and `base_wb_en` are asserted only in DONE.
- `start` in any state other than IDLE is ignored.

## Timing
- Accept at cycle T:
  - Stores: issues at T+1..T+N; DONE at T+N+1.
  - Loads: issues at T+1..T+N; writebacks at T+2..T+N+1; DONE at T+N+2 (the last writeback coincides with DRAIN).
  - N=0: DONE at T+1.
- Reset values: state IDLE, every output 0, `mem_op` 0.
- Outside XFER: `mem_write_en`=0, `mem_addr` holds its last value.
- `rst` mid-operation:
  - Next cycle is IDLE with all outputs 0.
  - A pending load writeback and the base writeback are discarded.
  - Memory writes issued before reset stand.
- The load writeback in DRAIN and `base_wb_en` in DONE never fall in the same cycle; the register file needs no second-port priority.

## Structure
- Shared `cpu_pkg` holds:
  - opcode patterns: `OP_STM`, `OP_LDM`, `OP_PUSH`, `OP_POP`, shared with `data_mem` decode;
  - `seq_state_t` enum;
  - register constants `REG_SP`=13, `REG_LR`=14, `REG_PC`=15.
- Sub-module `reg_list_pri_enc`: 16-bit lowest-set-bit encoder producing index and valid.
- Popcount is inline combinational logic.

## Test plan
- PUSH {R0,R2,LR}, SP=0x100:
  - stores at 0xF4/0xF8/0xFC of R0/R2/R14 on T+1..T+3, `mem_write_en`=1;
  - DONE at T+4 with SP←0xF4;
  - `stall` high T..T+3.
- POP {R1,PC}, SP=0xF8:
  - reads 0xF8 and 0xFC;
  - `wb` R1 at T+2, R15 at T+3;
  - DONE at T+4 with SP←0x100.
- LDMIA R3!,{R3,R4}, R3=0x40:
  - loads at 0x40/0x44;
  - `base_wb_en` stays 0;
  - STMIA R3!,{R5} writes back R3=0x44.
- Empty list STM:
  - `done` at T+1;
  - no `mem_write_en`, `wb_en` or `base_wb_en`.
- `rst` asserted at T+2 of a 4-register POP:
  - IDLE next cycle;
  - no further `wb_en` or `base_wb_en`;
  - a new PUSH is accepted the cycle after.
- `start` pulsed during XFER is ignored; PUSH with SP=0x4 and N=2 wraps to start address 0xFFFFFFFC.
